// File: rtl/nios_fetch_pkg.sv
// Shared constants for the fetch path: branch decode fields, ROM geometry, FSM encoding.
package nios_fetch_pkg;

    localparam logic [5:0]  OP_BR       = 6'h06;
    localparam logic [15:0] BR_SELF_IMM = 16'hFFFC;

    localparam int unsigned ROM_BYTES   = 256;
    localparam logic [31:0] ROM_PC_MAX  = 32'(ROM_BYTES - 4);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // "stop: br stop" encodes as opcode BR with a -4 byte offset.
    function automatic logic is_self_branch(input logic [31:0] inst);
        return (inst[5:0] == OP_BR) && (inst[21:6] == BR_SELF_IMM);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer of {pc,inst} entries; head visible combinationally, zero when empty.
// Push accepted when not full or popping the same cycle; flush overrides push and pop.
module fetch_fifo
    import nios_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: PC, ROM addressing, fetch buffer; first word valid two edges after start is sampled.
// Holds PC and stops capturing while the buffer is full and decode is not ready.
module instr_fetch_ctrl
    import nios_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] PC_MAX     = ROM_PC_MAX,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        fault
);

    logic [1:0]   state;
    logic [31:0]  pc;
    logic         start_q;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t head;
    fetch_entry_t cap_dat;
    logic         pop;
    logic         push;
    logic         redir_act;
    logic         redir_bad;
    logic         self_br;
    logic [32:0]  pc_next4;
    logic         overrun;

    assign pop       = inst_valid && inst_ready;
    assign redir_act = redirect_valid && ((state == ST_RUN) || (state == ST_HALT));
    assign redir_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc > PC_MAX);
    assign push      = (state == ST_RUN) && !redir_act && (!fifo_full || pop);
    assign self_br   = is_self_branch(rom_data);
    assign pc_next4  = {1'b0, pc} + 33'd4;
    assign overrun   = pc_next4 > {1'b0, PC_MAX};
    assign cap_dat   = '{pc: pc, inst: rom_data};

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat (cap_dat),
        .pop      (pop),
        .flush    (redir_act),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // start is registered first, so RUN begins one edge after it is sampled.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            pc      <= RESET_PC;
            start_q <= 1'b0;
        end else begin
            start_q <= (state == ST_IDLE) && start && !start_q;
            unique case (state)
                ST_IDLE: begin
                    if (start_q) state <= ST_RUN;
                end
                ST_RUN, ST_HALT: begin
                    if (redir_act) begin
                        if (redir_bad) begin
                            state <= ST_FAULT;
                        end else begin
                            pc    <= redirect_pc;
                            state <= ST_RUN;
                        end
                    end else if (push) begin
                        if (self_br) begin
                            state <= ST_HALT;
                        end else begin
                            pc <= pc_next4[31:0];
                            if (overrun) state <= ST_FAULT;
                        end
                    end
                end
                default: state <= ST_FAULT;
            endcase
        end
    end

    assign rom_addr   = pc;
    assign inst_valid = !fifo_empty;
    assign inst_data  = head.inst;
    assign inst_pc    = head.pc;
    assign halted     = (state == ST_HALT);
    assign fault      = (state == ST_FAULT);

endmodule
